// File: rtl/interrupt_controller.sv
// Interrupt controller for the multicycle MIPS core: synchronises and edge-detects
// maskable and NMI request lines, prioritises them and offers one at a time at preFetch.
module interrupt_controller #(
    parameter int                   NUM_IRQ    = 4,
    parameter int                   VEC_WIDTH  = 32,
    parameter logic [VEC_WIDTH-1:0] INT_BASE   = 32'h00000080,
    parameter int                   VEC_STRIDE = 16,
    parameter logic [VEC_WIDTH-1:0] NMI_VEC    = 32'h00000100
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [NUM_IRQ-1:0]   Irq,
    input  logic                 Nmi,
    input  logic                 INTD,
    input  logic                 MaskWe,
    input  logic [NUM_IRQ-1:0]   MaskIn,
    input  logic                 Boundary,
    input  logic                 Ack,
    input  logic                 Eret,
    output logic                 isInterrupted,
    output logic                 INA,
    output logic [2:0]           IntId,
    output logic [VEC_WIDTH-1:0] IntVector,
    output logic [NUM_IRQ-1:0]   Mask,
    output logic [NUM_IRQ:0]     Pending,
    output logic [1:0]           InService
);

    // Line NUM_IRQ of every per-line vector is the NMI.
    localparam int NL = NUM_IRQ + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    logic [NL-1:0]        pins;
    logic [NL-1:0]        sync1_q, sync2_q, prev_q;
    logic [NL-1:0]        edge_w;
    logic [NL-1:0]        clr_w;
    logic [NL-1:0]        pending_q, pending_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic                 nmi_active_q, nmi_active_d;
    logic                 int_active_q, int_active_d;
    state_t               state_q, state_d;
    logic                 is_int_q, is_int_d;
    logic                 ina_q, ina_d;
    logic [2:0]           int_id_q, int_id_d;
    logic [VEC_WIDTH-1:0] vec_q, vec_d;

    logic                 ack_take;
    logic [NUM_IRQ-1:0]   sel_w;
    logic                 cand_valid, cand_nmi;
    logic [2:0]           cand_id;
    logic [VEC_WIDTH-1:0] cand_vec;

    assign pins = {Nmi, Irq};

    // Per-line two-flop synchroniser plus previous-value register; reset to 0 so a
    // line already high when reset releases is reported as a rising edge.
    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_line
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    sync1_q[gi] <= 1'b0;
                    sync2_q[gi] <= 1'b0;
                    prev_q[gi]  <= 1'b0;
                end else begin
                    sync1_q[gi] <= pins[gi];
                    sync2_q[gi] <= sync1_q[gi];
                    prev_q[gi]  <= sync2_q[gi];
                end
            end
            assign edge_w[gi] = sync2_q[gi] & ~prev_q[gi];
        end
    endgenerate

    // Candidate selection: NMI first, then the lowest enabled maskable line.
    assign sel_w = pending_q[NUM_IRQ-1:0] & mask_q;

    always_comb begin
        cand_nmi   = pending_q[NUM_IRQ] & ~nmi_active_q;
        cand_valid = cand_nmi;
        cand_id    = 3'd0;
        if (!cand_nmi && !INTD && !int_active_q && !nmi_active_q && (|sel_w)) begin
            cand_valid = 1'b1;
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (sel_w[i]) begin
                    cand_id = 3'(i);
                end
            end
        end
    end

    assign cand_vec = cand_nmi ? NMI_VEC
                               : INT_BASE + VEC_WIDTH'(cand_id) * VEC_WIDTH'(VEC_STRIDE);

    // Offer FSM: an offer, once made, is held unchanged until the controller acks it.
    always_comb begin
        state_d  = state_q;
        is_int_d = is_int_q;
        ina_d    = ina_q;
        int_id_d = int_id_q;
        vec_d    = vec_q;
        ack_take = 1'b0;
        case (state_q)
            IDLE: begin
                if (Boundary && cand_valid) begin
                    state_d  = OFFER;
                    is_int_d = 1'b1;
                    ina_d    = ~cand_nmi;
                    int_id_d = cand_id;
                    vec_d    = cand_vec;
                end
            end
            OFFER: begin
                if (Ack) begin
                    ack_take = 1'b1;
                    state_d  = IDLE;
                    is_int_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                is_int_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        clr_w = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_w[i] = ack_take & ina_q & (int_id_q == 3'(i));
        end
        clr_w[NUM_IRQ] = ack_take & ~ina_q;
    end

    // A new edge wins over a same-cycle acknowledge clear.
    assign pending_d = (pending_q & ~clr_w) | edge_w;
    assign mask_d    = MaskWe ? MaskIn : mask_q;

    // Eret retires the innermost level first; a same-cycle Ack then marks the new one.
    always_comb begin
        nmi_active_d = nmi_active_q;
        int_active_d = int_active_q;
        if (Eret) begin
            if (nmi_active_q) begin
                nmi_active_d = 1'b0;
            end else begin
                int_active_d = 1'b0;
            end
        end
        if (ack_take) begin
            if (ina_q) begin
                int_active_d = 1'b1;
            end else begin
                nmi_active_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pending_q    <= '0;
            mask_q       <= '0;
            nmi_active_q <= 1'b0;
            int_active_q <= 1'b0;
            state_q      <= IDLE;
            is_int_q     <= 1'b0;
            ina_q        <= 1'b0;
            int_id_q     <= 3'd0;
            vec_q        <= '0;
        end else begin
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            nmi_active_q <= nmi_active_d;
            int_active_q <= int_active_d;
            state_q      <= state_d;
            is_int_q     <= is_int_d;
            ina_q        <= ina_d;
            int_id_q     <= int_id_d;
            vec_q        <= vec_d;
        end
    end

    assign isInterrupted = is_int_q;
    assign INA           = ina_q;
    assign IntId         = int_id_q;
    assign IntVector     = vec_q;
    assign Mask          = mask_q;
    assign Pending       = pending_q;
    assign InService     = {nmi_active_q, int_active_q};

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised bench for interrupt_controller against a cycle-level reference model
// built from pin-sample history and an offer/acknowledge bookkeeping record.
module tb_interrupt_controller;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [3:0]  Irq = '0;
    logic        Nmi = 1'b0;
    logic        INTD = 1'b0;
    logic        MaskWe = 1'b0;
    logic [3:0]  MaskIn = '0;
    logic        Boundary = 1'b0;
    logic        Ack = 1'b0;
    logic        Eret = 1'b0;
    logic        isInterrupted;
    logic        INA;
    logic [2:0]  IntId;
    logic [31:0] IntVector;
    logic [3:0]  Mask;
    logic [4:0]  Pending;
    logic [1:0]  InService;

    int n_tests = 0;
    int n_fail  = 0;

    interrupt_controller dut (
        .Clk(Clk), .Rst_n(Rst_n), .Irq(Irq), .Nmi(Nmi), .INTD(INTD),
        .MaskWe(MaskWe), .MaskIn(MaskIn), .Boundary(Boundary), .Ack(Ack), .Eret(Eret),
        .isInterrupted(isInterrupted), .INA(INA), .IntId(IntId), .IntVector(IntVector),
        .Mask(Mask), .Pending(Pending), .InService(InService)
    );

    always #5 Clk = ~Clk;

    // Reference state: hist[k] is the {Nmi,Irq} pin value sampled k edges ago.
    logic [4:0]  hist [4];
    logic [4:0]  m_pend;
    logic [3:0]  m_mask;
    bit          m_nact, m_iact;
    bit          m_off, m_ina;
    int          m_id;
    logic [31:0] m_vec;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) hist[k] = '0;
        m_pend = '0; m_mask = '0; m_nact = 0; m_iact = 0;
        m_off = 0; m_ina = 0; m_id = 0; m_vec = '0;
    endtask

    // One rising Clk: a pin change becomes pending three edges after it is first sampled.
    task automatic model_step();
        logic [4:0] rise, clr;
        bit nmi_pick, any_pick;
        int pick;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = {Nmi, Irq};
        rise = hist[2] & ~hist[3];
        nmi_pick = m_pend[4] && !m_nact;
        any_pick = nmi_pick;
        pick = 0;
        if (!nmi_pick && !INTD && !m_iact && !m_nact) begin
            for (int i = 0; i < 4; i++) begin
                if (!any_pick && m_pend[i] && m_mask[i]) begin
                    any_pick = 1; pick = i;
                end
            end
        end
        clr = '0;
        if (Eret) begin
            if (m_nact) m_nact = 0; else m_iact = 0;
        end
        if (!m_off) begin
            if (Boundary && any_pick) begin
                m_off = 1;
                m_ina = !nmi_pick;
                m_id  = pick;
                m_vec = nmi_pick ? 32'h100 : 32'h80 + 32'(pick) * 16;
            end
        end else if (Ack) begin
            m_off = 0;
            if (m_ina) begin clr[m_id] = 1'b1; m_iact = 1; end
            else       begin clr[4] = 1'b1;    m_nact = 1; end
        end
        m_pend = (m_pend & ~clr) | rise;
        if (MaskWe) m_mask = MaskIn;
    endtask

    task automatic compare_all();
        check_val("isInterrupted", 32'(isInterrupted), 32'(m_off));
        check_val("INA", 32'(INA), 32'(m_ina));
        check_val("IntId", 32'(IntId), 32'(m_id));
        check_val("IntVector", IntVector, m_vec);
        check_val("Mask", 32'(Mask), 32'(m_mask));
        check_val("Pending", 32'(Pending), 32'(m_pend));
        check_val("InService", 32'(InService), {30'd0, m_nact, m_iact});
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic pulse_reset();
        @(negedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        check_val("rst_isInterrupted", 32'(isInterrupted), 32'd0);
        check_val("rst_Pending", 32'(Pending), 32'd0);
        check_val("rst_Mask", 32'(Mask), 32'd0);
        check_val("rst_InService", 32'(InService), 32'd0);
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        Ack = 1'b0; Eret = 1'b0; MaskWe = 1'b0;
    endtask

    task automatic set_idle_inputs();
        MaskWe = 1'b0; Ack = 1'b0; Eret = 1'b0;
    endtask

    int next_rst;

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        compare_all();
        Rst_n = 1'b1;

        // Directed: line 2 rises with all lines enabled and Boundary held high.
        MaskWe = 1'b1; MaskIn = 4'b1111; Boundary = 1'b1;
        cycle();
        set_idle_inputs();
        Irq = 4'b0100;
        cycle();
        cycle();
        check_val("plan_pend_early", 32'(Pending), 32'd0);
        cycle();
        check_val("plan_pend_set", 32'(Pending), 32'b00100);
        cycle();
        check_val("plan_offer", {28'd0, isInterrupted, INA, IntId[1:0]}, 32'b1110);
        check_val("plan_vec", IntVector, 32'h000000A0);
        Ack = 1'b1;
        cycle();
        Ack = 1'b0;
        check_val("plan_ack_pend", 32'(Pending), 32'd0);
        check_val("plan_ack_insvc", 32'(InService), 32'b01);
        check_val("plan_ack_off", 32'(isInterrupted), 32'd0);
        Eret = 1'b1;
        cycle();
        Eret = 1'b0;
        Irq = 4'b0000;
        cycle();

        // Randomised traffic, with asynchronous resets landing while an offer is held.
        next_rst = 800;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc >= next_rst && m_off) begin
                pulse_reset();
                next_rst += 800;
            end
            if ($urandom_range(7) == 0) Irq[$urandom_range(3)] = ~Irq[$urandom_range(3)];
            if ($urandom_range(15) == 0) Nmi = ~Nmi;
            if ($urandom_range(31) == 0) INTD = ($urandom_range(3) == 0);
            MaskWe   = ($urandom_range(11) == 0);
            MaskIn   = 4'($urandom);
            Boundary = $urandom_range(1) == 1;
            Ack      = m_off ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            Eret     = ($urandom_range(9) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects external maskable interrupt lines and one non-maskable line for the multicycle MIPS core.
- Latches and prioritises pending requests and tracks in-service state.
- Offers one interrupt at a time to the main controller at an instruction boundary (the controller's preFetch state), with a handshake and a vector address.
- Sits between the pads and the main controller; drives the controller's interrupt-taken and interrupt-type inputs.

Parameters:
NUM_IRQ, 4, number of maskable interrupt lines (1..8)
VEC_WIDTH, 32, width of the vector address
INT_BASE, 32'h00000080, vector of maskable line 0
VEC_STRIDE, 16, byte spacing between maskable vectors
NMI_VEC, 32'h00000100, NMI vector

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Irq  input  NUM_IRQ  asynchronous maskable requests, rising-edge triggered
Nmi  input  1  asynchronous non-maskable request, rising-edge triggered
INTD  input  1  global maskable-interrupt disable from the core
MaskWe  input  1  write strobe for the mask register
MaskIn  input  NUM_IRQ  new mask value (1 = enabled)
Boundary  input  1  controller is at the instruction boundary (preFetch)
Ack  input  1  controller has saved the PC and is entering the handler
Eret  input  1  handler return, one-cycle pulse
isInterrupted  output  1  an interrupt is being offered
INA  output  1  offer type: 1 = maskable, 0 = NMI
IntId  output  3  index of the offered maskable line; 0 when NMI is offered
IntVector  output  VEC_WIDTH  handler address of the offered interrupt
Mask  output  NUM_IRQ  current mask register
Pending  output  NUM_IRQ+1  {nmi_pending, irq_pending}
InService  output  2  {nmi_active, int_active}

Behaviour:
- Reset (asynchronous, Rst_n=0) clears everything: synchronisers, edge registers, pending, mask (all masked), active flags, FSM in IDLE, isInterrupted=0, INA=0, IntId=0, IntVector=0.
- A line already high when reset is released is seen as a rising edge.
- Input path per line: two-flop synchroniser, then a previous-value register.
  - Edge = sync2 & ~prev.
  - The pending bit sets on the 3rd rising Clk after the pin rises (given setup is met).
  - Pulses shorter than one Clk period are not guaranteed to be seen.
- Pending bits stay set until they are acknowledged. Further edges on a set bit merge into it (no counting).
- If an edge and the Ack-clear hit the same bit in the same cycle, set wins.
- Mask register: MaskWe loads MaskIn on the next edge. The mask only gates selection, never the pending bits.
- Candidate selection is combinational, in priority order:
  1. nmi_pending & ~nmi_active selects NMI.
  2. Otherwise ~INTD & ~int_active & ~nmi_active & |(irq_pending & Mask) selects the lowest set index.
  3. Otherwise there is no candidate.
- FSM states are IDLE and OFFER.
  - IDLE: isInterrupted=0. If Boundary=1 and a candidate exists, register INA, IntId and IntVector, set isInterrupted=1 on the next edge, and go to OFFER. Otherwise stay in IDLE.
  - Vector: NMI gives NMI_VEC. Maskable gives INT_BASE + IntId*VEC_STRIDE, computed in VEC_WIDTH bits with wrap ignored.
  - OFFER: outputs are frozen; the offer is never withdrawn or replaced, even if a higher-priority request, an INTD change or a mask change arrives. Boundary is ignored.
  - OFFER on Ack=1, at the next edge:
    - Clear the offered pending bit.
    - Set nmi_active (NMI) or int_active (maskable).
    - isInterrupted=0, go to IDLE.
  - Minimum spacing between two offers is 2 cycles.
- Ack while in IDLE is ignored.
- Eret (any state): clears nmi_active if it is set, otherwise clears int_active. With neither set, it is ignored.
- Nesting:
  - An NMI may be offered while int_active=1.
  - Nothing is offered while nmi_active=1, except a new NMI edge, which stays pending until Eret.
  - Maskable interrupts never nest.
- Eret and Ack in the same cycle: Eret clears first, then Ack sets the new flag. The final state is active for the newly acked type.

Test Plan:
- Irq=4'b0100 rises, Mask=4'b1111, Boundary held 1 → Pending[2]=1 three cycles later. Next cycle isInterrupted=1, INA=1, IntId=2, IntVector=32'h000000A0. Ack → Pending=0, InService=2'b01, isInterrupted=0.
- Irq[1] and Irq[3] rise together, Mask=4'b1111 → IntId=1 is offered first. After Ack and Eret, the next Boundary offers IntId=3 with vector 32'h000000B0.
- int_active=1 and Nmi rises → at Boundary, INA=0, IntVector=32'h00000100. Ack → InService=2'b11. First Eret → 2'b01, second Eret → 2'b00.
- Irq[0] pending with Mask=0 or INTD=1 → no offer. Write Mask=4'b0001 with INTD=0 → offer IntId=0 at the next Boundary.
- OFFER state with an NMI arriving and Boundary toggling → maskable offer stays unchanged until Ack. NMI is offered at the next Boundary.
- Rst_n pulsed low during OFFER → isInterrupted=0, Pending=0, Mask=0 immediately. Irq held high through reset → pending again 3 cycles after release.
